// File: rtl/regfile_dump_pkg.sv
// Shared types and sizes for the register-file dump engine (regfile_dump).
// Covers the state encoding and the register file geometry.
package regfile_dump_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    FIN
  } state_t;

  // Register 0 is hardwired zero, so it can be left out of a dump.
  function automatic logic is_skipped(input logic skip_zero,
                                      input logic [REG_ADDR_W-1:0] addr);
    return skip_zero && (addr == '0);
  endfunction

endpackage

// File: rtl/regfile_dump.sv
// Streams a range of register file entries out over a valid/ready port.
// Optional write-back "poke" path is enabled with `define REGFILE_DUMP_POKE_EN.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [REG_ADDR_W-1:0] first_addr,
  input  logic [REG_ADDR_W-1:0] last_addr,
  output logic                  busy,
  output logic                  done,
  output logic [REG_ADDR_W-1:0] rf_addr,
  input  logic [REG_DATA_W-1:0] rf_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_ADDR_W-1:0] out_addr,
  output logic [REG_DATA_W-1:0] out_data
`ifdef REGFILE_DUMP_POKE_EN
  ,
  input  logic                  poke_req,
  input  logic [REG_ADDR_W-1:0] poke_addr,
  input  logic [REG_DATA_W-1:0] poke_data,
  output logic                  poke_ack,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [REG_DATA_W-1:0] rf_wdata
`endif
);

  state_t                  state;
  logic [REG_ADDR_W-1:0]   cur;
  logic [REG_ADDR_W-1:0]   last;
  logic                    take_start;

  assign rf_addr = cur;

`ifdef REGFILE_DUMP_POKE_EN
  // A poke in IDLE takes priority over a simultaneous start; writes to r0 are acked but dropped.
  assign poke_ack   = poke_req && (state == IDLE);
  assign rf_we      = poke_ack && (poke_addr != '0);
  assign rf_waddr   = poke_addr;
  assign rf_wdata   = poke_data;
  assign take_start = start && !poke_req;
`else
  assign take_start = start;
`endif

  // done is registered out of FIN, so it pulses in the first IDLE cycle after a dump.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur       <= '0;
      last      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (take_start) begin
            last  <= last_addr;
            cur   <= first_addr;
            busy  <= 1'b1;
            state <= (first_addr > last_addr) ? FIN : FETCH;
          end
        end
        FETCH: begin
          if (is_skipped(SKIP_ZERO, cur)) begin
            if (cur == last) state <= FIN;
            else             cur   <= cur + 5'd1;
          end else begin
            out_addr  <= cur;
            out_data  <= rf_data;
            out_valid <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          // Comparing against last (not a wrapped increment) lets a dump end at r31.
          if (out_ready) begin
            out_valid <= 1'b0;
            if (cur == last) begin
              state <= FIN;
            end else begin
              cur   <= cur + 5'd1;
              state <= FETCH;
            end
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: table-driven dumps plus stall, reset and poke sequences.
// Poke checks are compiled only when REGFILE_DUMP_POKE_EN is defined.
module tb_regfile_dump;
  import regfile_dump_pkg::*;

  typedef struct {
    logic [4:0]        first;
    logic [4:0]        last;
    int                n;
    logic [2:0][4:0]   addr;
    logic [2:0][31:0]  data;
    int                firstLat;
    int                doneLat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        out_ready = 1'b1;
  logic [4:0]  first_addr = '0;
  logic [4:0]  last_addr = '0;

  logic        busy1, done1, out_valid1;
  logic [4:0]  rf_addr1, out_addr1;
  logic [31:0] rf_data1, out_data1;
  logic        busy0, done0, out_valid0;
  logic [4:0]  rf_addr0, out_addr0;
  logic [31:0] rf_data0, out_data0;

`ifdef REGFILE_DUMP_POKE_EN
  logic        poke_req = 1'b0;
  logic [4:0]  poke_addr = '0;
  logic [31:0] poke_data = '0;
  logic        poke_ack1, rf_we1, poke_ack0, rf_we0;
  logic [4:0]  rf_waddr1, rf_waddr0;
  logic [31:0] rf_wdata1, rf_wdata0;
`endif

  regfile_dump #(.SKIP_ZERO(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .first_addr(first_addr), .last_addr(last_addr),
    .busy(busy1), .done(done1), .rf_addr(rf_addr1), .rf_data(rf_data1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_addr(out_addr1), .out_data(out_data1)
`ifdef REGFILE_DUMP_POKE_EN
    , .poke_req(poke_req), .poke_addr(poke_addr), .poke_data(poke_data), .poke_ack(poke_ack1),
    .rf_we(rf_we1), .rf_waddr(rf_waddr1), .rf_wdata(rf_wdata1)
`endif
  );

  regfile_dump #(.SKIP_ZERO(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .first_addr(first_addr), .last_addr(last_addr),
    .busy(busy0), .done(done0), .rf_addr(rf_addr0), .rf_data(rf_data0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_addr(out_addr0), .out_data(out_data0)
`ifdef REGFILE_DUMP_POKE_EN
    , .poke_req(1'b0), .poke_addr(5'd0), .poke_data(32'd0), .poke_ack(poke_ack0),
    .rf_we(rf_we0), .rf_waddr(rf_waddr0), .rf_wdata(rf_wdata0)
`endif
  );

  always #5 clk = ~clk;

  // Register file model: r[i] = i*0x11 loaded on the first edge, r0 stays zero.
  logic [31:0] regs [NUM_REGS];
  logic        loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'h11 * 32'(i);
      loaded <= 1'b1;
    end
`ifdef REGFILE_DUMP_POKE_EN
    else if (rf_we1 && rf_waddr1 != 5'd0) regs[rf_waddr1] <= rf_wdata1;
`endif
  end
  assign rf_data1 = regs[rf_addr1];
  assign rf_data0 = regs[rf_addr0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Word/done monitor, sampled on the falling edge.
  logic [4:0]  qa1[$];
  logic [31:0] qd1[$];
  int          qc1[$];
  logic [4:0]  qa0[$];
  logic [31:0] qd0[$];
  int          doneCnt = 0;
  int          doneCyc = 0;
  always @(negedge clk) begin
    if (out_valid1 && out_ready) begin
      qa1.push_back(out_addr1);
      qd1.push_back(out_data1);
      qc1.push_back(cyc);
    end
    if (out_valid0 && out_ready) begin
      qa0.push_back(out_addr0);
      qd0.push_back(out_data0);
    end
    if (done1) begin
      doneCnt = doneCnt + 1;
      doneCyc = cyc;
    end
  end

  int compared = 0;
  int mismatched = 0;
  int startCyc = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared = compared + 1;
    if (act !== exp) begin
      mismatched = mismatched + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clearMonitor();
    qa1.delete(); qd1.delete(); qc1.delete();
    qa0.delete(); qd0.delete();
    doneCnt = 0;
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while ((busy1 || busy0) && n < 200) begin
      nextCycle();
      n++;
    end
    checkOutput({name, " idle_timeout"}, 32'(n < 200), 32'd1);
    nextCycle();
    nextCycle();
  endtask

  task automatic applyStimulus(input logic [4:0] f, input logic [4:0] l);
    clearMonitor();
    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
    startCyc   = cyc;
    nextCycle();
    start = 1'b0;
    waitIdle($sformatf("dump %0d..%0d", f, l));
  endtask

  function automatic vec_t mkVec(input logic [4:0] f, input logic [4:0] l, input int n,
                                 input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                                 input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                                 input int fl, input int dl);
    vec_t v;
    v.first = f; v.last = l; v.n = n;
    v.addr[0] = a0; v.addr[1] = a1; v.addr[2] = a2;
    v.data[0] = d0; v.data[1] = d1; v.data[2] = d2;
    v.firstLat = fl; v.doneLat = dl;
    return v;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[6];
    vecs[0] = mkVec(5'd1,  5'd3,  3, 5'd1,  5'd2,  5'd3, 32'h11,  32'h22,  32'h33, 2, 8);
    vecs[1] = mkVec(5'd0,  5'd2,  2, 5'd1,  5'd2,  5'd0, 32'h11,  32'h22,  32'h0,  3, 7);
    vecs[2] = mkVec(5'd31, 5'd31, 1, 5'd31, 5'd0,  5'd0, 32'h20F, 32'h0,   32'h0,  2, 4);
    vecs[3] = mkVec(5'd5,  5'd4,  0, 5'd0,  5'd0,  5'd0, 32'h0,   32'h0,   32'h0,  0, 2);
    vecs[4] = mkVec(5'd0,  5'd0,  0, 5'd0,  5'd0,  5'd0, 32'h0,   32'h0,   32'h0,  0, 3);
    vecs[5] = mkVec(5'd30, 5'd31, 2, 5'd30, 5'd31, 5'd0, 32'h1FE, 32'h20F, 32'h0,  2, 6);

    // Reset state
    nextCycle();
    nextCycle();
    checkOutput("reset busy",      32'(busy1),      32'd0);
    checkOutput("reset done",      32'(done1),      32'd0);
    checkOutput("reset out_valid", 32'(out_valid1), 32'd0);
    checkOutput("reset out_addr",  32'(out_addr1),  32'd0);
    checkOutput("reset out_data",  out_data1,       32'd0);
    checkOutput("reset rf_addr",   32'(rf_addr1),   32'd0);
    rst = 1'b0;
    nextCycle();

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].first, vecs[i].last);
      checkOutput($sformatf("v%0d count", i), 32'(qa1.size()), 32'(vecs[i].n));
      for (int k = 0; k < vecs[i].n && k < qa1.size(); k++) begin
        checkOutput($sformatf("v%0d addr[%0d]", i, k), 32'(qa1[k]), 32'(vecs[i].addr[k]));
        checkOutput($sformatf("v%0d data[%0d]", i, k), qd1[k], vecs[i].data[k]);
        checkOutput($sformatf("v%0d cycle[%0d]", i, k), 32'(qc1[k] - startCyc),
                    32'(vecs[i].firstLat + 2 * k));
      end
      checkOutput($sformatf("v%0d done count", i), 32'(doneCnt), 32'd1);
      checkOutput($sformatf("v%0d done cycle", i), 32'(doneCyc - startCyc), 32'(vecs[i].doneLat));
    end

    // SKIP_ZERO=0 instance emits r0 as zero
    applyStimulus(5'd0, 5'd2);
    checkOutput("noskip count", 32'(qa0.size()), 32'd3);
    if (qa0.size() >= 3) begin
      checkOutput("noskip addr0", 32'(qa0[0]), 32'd0);
      checkOutput("noskip data0", qd0[0],      32'd0);
      checkOutput("noskip addr1", 32'(qa0[1]), 32'd1);
      checkOutput("noskip data2", qd0[2],      32'h22);
    end

    // Backpressure: out_ready low for 5 cycles during the first SEND
    begin
      int n = 0;
      clearMonitor();
      out_ready  = 1'b0;
      first_addr = 5'd1;
      last_addr  = 5'd3;
      start      = 1'b1;
      nextCycle();
      start = 1'b0;
      while (!out_valid1 && n < 20) begin
        nextCycle();
        n++;
      end
      checkOutput("stall valid_timeout", 32'(n < 20), 32'd1);
      for (int k = 0; k < 5; k++) begin
        checkOutput($sformatf("stall valid[%0d]", k), 32'(out_valid1), 32'd1);
        checkOutput($sformatf("stall addr[%0d]", k),  32'(out_addr1),  32'd1);
        checkOutput($sformatf("stall data[%0d]", k),  out_data1,       32'h11);
        nextCycle();
      end
      out_ready = 1'b1;
      waitIdle("stall");
      checkOutput("stall count", 32'(qa1.size()), 32'd3);
      if (qa1.size() >= 3) begin
        checkOutput("stall word0", 32'(qa1[0]), 32'd1);
        checkOutput("stall word1", 32'(qa1[1]), 32'd2);
        checkOutput("stall word2", 32'(qa1[2]), 32'd3);
      end
      checkOutput("stall done count", 32'(doneCnt), 32'd1);
    end

    // Reset during the second SEND aborts without a done pulse
    clearMonitor();
    out_ready  = 1'b1;
    first_addr = 5'd1;
    last_addr  = 5'd3;
    start      = 1'b1;
    nextCycle();
    start = 1'b0;
    nextCycle();
    nextCycle();
    nextCycle();
    checkOutput("abort pre valid", 32'(out_valid1), 32'd1);
    checkOutput("abort pre addr",  32'(out_addr1),  32'd2);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort busy",      32'(busy1),      32'd0);
    checkOutput("abort out_valid", 32'(out_valid1), 32'd0);
    checkOutput("abort out_addr",  32'(out_addr1),  32'd0);
    checkOutput("abort out_data",  out_data1,       32'd0);
    checkOutput("abort rf_addr",   32'(rf_addr1),   32'd0);
    nextCycle();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) nextCycle();
    checkOutput("abort no done",    32'(doneCnt),     32'd0);
    checkOutput("abort word count", 32'(qa1.size()), 32'd1);
    applyStimulus(5'd1, 5'd3);
    checkOutput("after abort count", 32'(qa1.size()), 32'd3);
    if (qa1.size() >= 3) begin
      checkOutput("after abort addr2", 32'(qa1[2]), 32'd3);
      checkOutput("after abort data2", qd1[2],      32'h33);
    end
    checkOutput("after abort done", 32'(doneCnt), 32'd1);

`ifdef REGFILE_DUMP_POKE_EN
    // Poke r7 together with a start: the poke wins and the start is dropped
    poke_req   = 1'b1;
    poke_addr  = 5'd7;
    poke_data  = 32'hDEADBEEF;
    first_addr = 5'd1;
    last_addr  = 5'd3;
    start      = 1'b1;
    #1;
    checkOutput("poke ack",   32'(poke_ack1), 32'd1);
    checkOutput("poke we",    32'(rf_we1),    32'd1);
    checkOutput("poke waddr", 32'(rf_waddr1), 32'd7);
    checkOutput("poke wdata", rf_wdata1,      32'hDEADBEEF);
    nextCycle();
    poke_req = 1'b0;
    start    = 1'b0;
    checkOutput("poke start dropped", 32'(busy1), 32'd0);
    waitIdle("poke");

    poke_req  = 1'b1;
    poke_addr = 5'd0;
    poke_data = 32'h12345678;
    #1;
    checkOutput("poke r0 ack", 32'(poke_ack1), 32'd1);
    checkOutput("poke r0 we",  32'(rf_we1),    32'd0);
    nextCycle();
    poke_req = 1'b0;

    applyStimulus(5'd7, 5'd7);
    checkOutput("poke dump count", 32'(qa1.size()), 32'd1);
    if (qa1.size() >= 1) begin
      checkOutput("poke dump addr", 32'(qa1[0]), 32'd7);
      checkOutput("poke dump data", qd1[0],      32'hDEADBEEF);
    end

    first_addr = 5'd1;
    last_addr  = 5'd3;
    start      = 1'b1;
    nextCycle();
    start     = 1'b0;
    poke_req  = 1'b1;
    poke_addr = 5'd9;
    poke_data = 32'hCAFEF00D;
    #1;
    checkOutput("poke busy ack", 32'(poke_ack1), 32'd0);
    checkOutput("poke busy we",  32'(rf_we1),    32'd0);
    poke_req = 1'b0;
    waitIdle("poke busy");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
